// File: rtl/mac3_stream.sv
// Streaming three-sample multiply-add: for every run of >=3 consecutive valid samples,
// emits (oldest*middle + newest) mod 2**DW one cycle after the newest sample arrives.
module mac3_stream #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             validi,
  input  logic [DW-1:0]    data_in,
  output logic             valido,
  output logic [DW-1:0]    data_out,
  output logic             ovf,
  output logic [CNT_W-1:0] res_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ONE  = 2'd1;
  localparam logic [1:0] TWO  = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DW-1:0]    w1_q, w1_d;
  logic [DW-1:0]    w2_q, w2_d;
  logic             valido_q, valido_d;
  logic [DW-1:0]    data_out_q, data_out_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic [2*DW-1:0]  prod;
  logic [2*DW:0]    sum;
  logic             emit;

  always_comb begin
    prod = {{DW{1'b0}}, w2_q} * {{DW{1'b0}}, w1_q};
    sum  = {1'b0, prod} + {{(DW+1){1'b0}}, data_in};
    emit = validi && ((state_q == TWO) || (state_q == RUN));

    state_d = IDLE;
    if (validi) begin
      case (state_q)
        IDLE:    state_d = ONE;
        ONE:     state_d = TWO;
        default: state_d = RUN;
      endcase
    end

    // A gap flushes the window so stale samples (or X data) can never leak into a result.
    if (validi) begin
      w2_d = w1_q;
      w1_d = data_in;
    end else begin
      w2_d = '0;
      w1_d = '0;
    end

    valido_d   = emit;
    data_out_d = emit ? sum[DW-1:0] : '0;
    ovf_d      = emit && (sum[2*DW:DW] != '0);

    res_cnt_d = res_cnt_q;
    if (emit && (res_cnt_q != '1)) begin
      res_cnt_d = res_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q    <= IDLE;
      w1_q       <= '0;
      w2_q       <= '0;
      valido_q   <= 1'b0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
      res_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      valido_q   <= valido_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  assign valido   = valido_q;
  assign data_out = data_out_q;
  assign ovf      = ovf_q;
  assign res_cnt  = res_cnt_q;

endmodule
